// File: rtl/snax_tcdm_responder_pkg.sv
// rtl/snax_tcdm_responder_pkg.sv - shared widths, index types and TCDM request/response structs
package snax_tcdm_responder_pkg;

  localparam int unsigned TcdmDataWidth = 64;
  localparam int unsigned TcdmAddrWidth = 17;
  localparam int unsigned TcdmNrPorts   = 16;
  localparam int unsigned TcdmNrBanks   = 32;
  localparam int unsigned TcdmBankDepth = 512;
  localparam int unsigned TcdmStrbWidth = TcdmDataWidth / 8;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned bank_w(input int unsigned nr_banks);
    return $clog2(nr_banks);
  endfunction

  // Row bits are whatever remains of the word address above the bank bits.
  function automatic int unsigned row_w(input int unsigned addr_width, input int unsigned nr_banks);
    return addr_width - 3 - $clog2(nr_banks);
  endfunction

  typedef logic [bank_w(TcdmNrBanks)-1:0]              bank_sel_t;
  typedef logic [idx_w(TcdmNrPorts)-1:0]               port_idx_t;
  typedef logic [row_w(TcdmAddrWidth, TcdmNrBanks)-1:0] row_t;

  typedef struct packed {
    logic      valid;
    bank_sel_t bank;
    row_t      row;
  } rsp_pending_t;

  typedef struct packed {
    logic [TcdmAddrWidth-1:0] addr;
    logic                     write;
    logic [3:0]               amo;
    logic [TcdmDataWidth-1:0] data;
    logic [TcdmStrbWidth-1:0] strb;
    logic                     user;
  } tcdm_req_chan_t;

  typedef struct packed {
    logic           q_valid;
    tcdm_req_chan_t q;
  } tcdm_req_t;

  typedef struct packed {
    logic [TcdmDataWidth-1:0] data;
  } tcdm_rsp_chan_t;

  typedef struct packed {
    logic           q_ready;
    logic           p_valid;
    tcdm_rsp_chan_t p;
  } tcdm_rsp_t;

endpackage

// File: rtl/snax_tcdm_rr_arbiter.sv
// rtl/snax_tcdm_rr_arbiter.sv - one-hot round-robin arbiter; pointer moves past the winner
module snax_tcdm_rr_arbiter
  import snax_tcdm_responder_pkg::*;
#(
  parameter int unsigned NrPorts = TcdmNrPorts
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NrPorts-1:0] req,
  output logic [NrPorts-1:0] gnt
);

  localparam int unsigned IdxW = idx_w(NrPorts);

  logic [IdxW-1:0] ptr;
  logic [IdxW-1:0] win;
  logic [IdxW-1:0] idx;
  logic            found;

  // Scan starting at the pointer; the first requester found wins.
  always_comb begin
    gnt   = '0;
    win   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < NrPorts; i++) begin
      idx = IdxW'((32'(ptr) + i) % NrPorts);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        win      = idx;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= IdxW'((32'(win) + 1) % NrPorts);
    end
  end

endmodule

// File: rtl/snax_tcdm_responder.sv
// rtl/snax_tcdm_responder.sv - banked word-interleaved TCDM scratchpad with per-bank RR arbitration
module snax_tcdm_responder
  import snax_tcdm_responder_pkg::*;
#(
  parameter int unsigned DataWidth = TcdmDataWidth,
  parameter int unsigned AddrWidth = TcdmAddrWidth,
  parameter int unsigned NrPorts   = TcdmNrPorts,
  parameter int unsigned NrBanks   = TcdmNrBanks,
  parameter int unsigned BankDepth = TcdmBankDepth
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  tcdm_req_t [NrPorts-1:0] tcdm_req_i,
  output tcdm_rsp_t [NrPorts-1:0] tcdm_rsp_o
);

  localparam int unsigned BankW   = bank_w(NrBanks);
  localparam int unsigned RowW    = row_w(AddrWidth, NrBanks);
  localparam int unsigned RowIdxW = idx_w(BankDepth);
  localparam int unsigned StrbW   = DataWidth / 8;
  localparam logic [RowW:0] DepthLim = (RowW + 1)'(BankDepth);

  typedef struct packed {
    logic             valid;
    logic [BankW-1:0] bank;
    logic [RowW-1:0]  row;
  } pend_t;

  logic [BankW-1:0]                  bank_of [NrPorts];
  logic [RowW-1:0]                   row_of  [NrPorts];
  logic [NrPorts-1:0]                in_range;
  logic [NrPorts-1:0]                ready;
  logic [NrBanks-1:0][NrPorts-1:0]   bank_req;
  logic [NrBanks-1:0][NrPorts-1:0]   bank_gnt;
  pend_t                             pend [NrPorts];
  logic [DataWidth-1:0]              mem  [NrBanks][BankDepth];
  logic                              unused_bits;

  // Byte offset, AMO opcode and user bits carry no meaning for this memory.
  always_comb begin
    unused_bits = 1'b0;
    for (int p = 0; p < NrPorts; p++) begin
      bank_of[p]  = tcdm_req_i[p].q.addr[3 +: BankW];
      row_of[p]   = tcdm_req_i[p].q.addr[3 + BankW +: RowW];
      in_range[p] = {1'b0, row_of[p]} < DepthLim;
      unused_bits = unused_bits ^ (^{tcdm_req_i[p].q.addr[2:0], tcdm_req_i[p].q.amo,
                                     tcdm_req_i[p].q.user});
    end
  end

  always_comb begin
    bank_req = '0;
    for (int b = 0; b < NrBanks; b++) begin
      for (int p = 0; p < NrPorts; p++) begin
        bank_req[b][p] = rst_ni && tcdm_req_i[p].q_valid && (bank_of[p] == BankW'(b));
      end
    end
  end

  for (genvar b = 0; b < NrBanks; b++) begin : g_bank_arb
    snax_tcdm_rr_arbiter #(
      .NrPorts (NrPorts)
    ) i_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req    (bank_req[b]),
      .gnt    (bank_gnt[b])
    );
  end

  always_comb begin
    for (int p = 0; p < NrPorts; p++) begin
      ready[p] = bank_gnt[bank_of[p]][p];
    end
  end

  // At most one grant per bank, so granted ports never collide on a bank.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NrPorts; p++) begin
      if (ready[p] && tcdm_req_i[p].q.write && in_range[p]) begin
        for (int k = 0; k < StrbW; k++) begin
          if (tcdm_req_i[p].q.strb[k]) begin
            mem[bank_of[p]][row_of[p][RowIdxW-1:0]][8*k +: 8] <= tcdm_req_i[p].q.data[8*k +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NrPorts; p++) begin
      if (!rst_ni) begin
        pend[p] <= '0;
      end else begin
        pend[p].valid <= ready[p] && !tcdm_req_i[p].q.write;
        pend[p].bank  <= bank_of[p];
        pend[p].row   <= row_of[p];
      end
    end
  end

  // Array is read in the return cycle so a write granted one cycle earlier is visible.
  always_comb begin
    for (int p = 0; p < NrPorts; p++) begin
      tcdm_rsp_o[p]         = '0;
      tcdm_rsp_o[p].q_ready = ready[p];
      tcdm_rsp_o[p].p_valid = pend[p].valid;
      if (pend[p].valid && ({1'b0, pend[p].row} < DepthLim)) begin
        tcdm_rsp_o[p].p.data = mem[pend[p].bank][pend[p].row[RowIdxW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_snax_tcdm_responder.sv
// tb/tb_snax_tcdm_responder.sv - directed scoreboard bench for snax_tcdm_responder
module tb_snax_tcdm_responder;
  import snax_tcdm_responder_pkg::*;

  localparam int NP = 16;
  localparam int NB = 32;
  localparam int BD = 256;

  typedef struct {
    int          cyc;
    logic [63:0] data;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_ni = 1'b0;
  tcdm_req_t [NP-1:0]  req;
  tcdm_rsp_t [NP-1:0]  rsp;

  logic        vld   [NP];
  logic [16:0] addr  [NP];
  logic        wr    [NP];
  logic [63:0] wdata [NP];
  logic [7:0]  strb  [NP];
  logic [63:0] exp_rd[NP];

  exp_t sb [NP][$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  snax_tcdm_responder #(
    .DataWidth (64),
    .AddrWidth (17),
    .NrPorts   (NP),
    .NrBanks   (NB),
    .BankDepth (BD)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .tcdm_req_i (req),
    .tcdm_rsp_o (rsp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      req[p]         = '0;
      req[p].q_valid = vld[p];
      req[p].q.addr  = addr[p];
      req[p].q.write = wr[p];
      req[p].q.data  = wdata[p];
      req[p].q.strb  = strb[p];
      req[p].q.amo   = 4'h3;
    end
  end

  // Response monitor: every p_valid must match the oldest expectation of that port, on time.
  always @(negedge clk) begin
    logic [63:0] idle_or;
    exp_t        e;
    idle_or = '0;
    for (int p = 0; p < NP; p++) begin
      if (rsp[p].p_valid === 1'b1) begin
        checks++;
        if (sb[p].size() == 0) begin
          errors++;
          $display("FAIL unexpected_p_valid port %0d cycle %0d data %h required no response",
                   p, cyc, rsp[p].p.data);
        end else begin
          e = sb[p].pop_front();
          if (e.cyc != cyc || rsp[p].p.data !== e.data) begin
            errors++;
            $display("FAIL rd_resp port %0d got cycle %0d data %h required cycle %0d data %h",
                     p, cyc, rsp[p].p.data, e.cyc, e.data);
          end
        end
      end else begin
        idle_or = idle_or | rsp[p].p.data;
      end
    end
    if (cyc > 0) begin
      checks++;
      if (idle_or !== 64'h0) begin
        errors++;
        $display("FAIL idle_data cycle %0d got %h required 0", cyc, idle_or);
      end
    end
  end

  task automatic clear();
    for (int p = 0; p < NP; p++) begin
      vld[p] = 1'b0; addr[p] = '0; wr[p] = 1'b0;
      wdata[p] = '0; strb[p] = '0; exp_rd[p] = '0;
    end
  endtask

  task automatic do_wr(input int p, input logic [16:0] a, input logic [63:0] d, input logic [7:0] s);
    vld[p] = 1'b1; wr[p] = 1'b1; addr[p] = a; wdata[p] = d; strb[p] = s;
  endtask

  task automatic do_rd(input int p, input logic [16:0] a, input logic [63:0] e);
    vld[p] = 1'b1; wr[p] = 1'b0; addr[p] = a; exp_rd[p] = e;
  endtask

  // Checks grants mid-cycle, queues expected read data for granted reads, then advances a cycle.
  task automatic step(input logic [NP-1:0] exp_ready, input string name);
    logic [NP-1:0] got;
    exp_t          e;
    @(negedge clk);
    for (int p = 0; p < NP; p++) got[p] = rsp[p].q_ready;
    checks++;
    if (got !== exp_ready) begin
      errors++;
      $display("FAIL %s q_ready got %h required %h", name, got, exp_ready);
    end
    for (int p = 0; p < NP; p++) begin
      if (exp_ready[p] && vld[p] && !wr[p]) begin
        e.cyc  = cyc + 1;
        e.data = exp_rd[p];
        sb[p].push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d required completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NP-1:0] got;
    clear();
    @(posedge clk);
    #1;
    do_rd(0, 17'h0100, 64'h0);
    step(16'h0000, "reset_ready_a");
    step(16'h0000, "reset_ready_b");
    rst_ni = 1'b1;
    clear();

    // Port 15 as last bank-0 winner leaves that pointer back at port 0.
    do_wr(15, 17'h0000, 64'h0123_4567_89AB_CDEF, 8'hFF);
    step(16'h8000, "t3_prep_wr");
    clear();
    do_rd(0, 17'h0000, 64'h0123_4567_89AB_CDEF);
    do_rd(3, 17'h0000, 64'h0123_4567_89AB_CDEF);
    do_rd(7, 17'h0000, 64'h0123_4567_89AB_CDEF);
    step(16'h0001, "t3_rr_p0");
    step(16'h0008, "t3_rr_p3");
    step(16'h0080, "t3_rr_p7");
    step(16'h0001, "t3_rr_p0_again");
    clear();

    do_wr(0, 17'h0100, 64'h1122_3344_5566_7788, 8'hFF);
    step(16'h0001, "t1_wr");
    clear();
    do_rd(0, 17'h0100, 64'h1122_3344_5566_7788);
    step(16'h0001, "t1_rd");
    clear();

    do_wr(0, 17'h0100, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    step(16'h0001, "t2_wr");
    clear();
    do_rd(0, 17'h0100, 64'h1122_3344_AAAA_AAAA);
    step(16'h0001, "t2_rd");
    clear();

    for (int i = 0; i < NP; i++) do_wr(i, 17'(i * 8), 64'hC0DE_0000_0000_0000 | 64'(i), 8'hFF);
    step(16'hFFFF, "t4_wr_all");
    clear();
    for (int i = 0; i < NP; i++) do_rd(i, 17'(i * 8), 64'hC0DE_0000_0000_0000 | 64'(i));
    step(16'hFFFF, "t4_rd_all");
    clear();

    // Grant seen, then reset lands on the edge that would have launched the read.
    vld[5] = 1'b1; addr[5] = 17'h0100;
    @(negedge clk);
    for (int p = 0; p < NP; p++) got[p] = rsp[p].q_ready;
    checks++;
    if (got !== 16'h0020) begin
      errors++;
      $display("FAIL t5_pre_reset_grant q_ready got %h required %h", got, 16'h0020);
    end
    #1 rst_ni = 1'b0;
    @(posedge clk);
    #1;
    step(16'h0000, "t5_reset_ready");
    rst_ni = 1'b1;
    clear();
    do_rd(0, 17'h0100, 64'h1122_3344_AAAA_AAAA);
    do_rd(15, 17'h0100, 64'h1122_3344_AAAA_AAAA);
    step(16'h0001, "t5_ptr_reset_p0");
    vld[0] = 1'b0;
    step(16'h8000, "t5_ptr_reset_p15");
    clear();

    do_wr(2, 17'h10000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    step(16'h0004, "t6_oor_wr");
    clear();
    do_rd(2, 17'h10000, 64'h0);
    step(16'h0004, "t6_oor_rd");
    clear();
    do_rd(0, 17'h0000, 64'hC0DE_0000_0000_0000);
    step(16'h0001, "t6_row0_intact");
    clear();

    repeat (3) @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (sb[p].size() != 0) begin
        errors++;
        $display("FAIL missing_resp port %0d pending %0d required 0", p, sb[p].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
